onehot_step_sequencer: RTL
==========================

Name: onehot_step_sequencer

Overview:
Registered step sequencer for the CPU control unit: a binary step register drives a registered one-hot step bus of N_OUT lines, T0..T(N_OUT-1), that enables control-signal groups.
- Generalises the combinational 4-to-10 one-hot decode: width and output count are parametrised, and it adds load, advance, clear, wrap/saturate mode, done/wrap pulses and a sticky range error.
- Sits between the instruction FSM and the datapath enables.

Parameters:
SEL_W, 4, width of binary step register and load value
N_OUT, 10, number of one-hot step lines; legal range 2..2**SEL_W
WRAP, 1, 1 = advance past last step returns to step 0; 0 = saturate at last step

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous return to step 0, clears error
load  input  1  load load_val into step register
load_val  input  SEL_W  binary step to load
advance  input  1  increment step by one
step  output  SEL_W  current binary step (registered)
onehot  output  N_OUT  registered one-hot of step; all-zero when invalid
wrap  output  1  one-cycle pulse: advanced from last step to step 0 (WRAP=1)
done  output  1  level: step == N_OUT-1 and not invalid
err  output  1  sticky: an out-of-range load occurred

Behaviour:
- Reset (Resetn=0, async, any time): step=0, onehot=1 (bit 0 only), wrap=0, err=0, invalid=0. done=0 (N_OUT>=2).
- Reset mid-sequence discards the current step; first edge after release behaves as from step 0.
- All outputs are registered; nothing is combinational from inputs to outputs. A command sampled at edge k is visible on step/onehot/done after edge k.
- step and onehot always update on the same edge. They are never skewed by a cycle.
- Command priority per edge: clear > load > advance > hold.
- clear: step=0, onehot=1, invalid=0, err=0, wrap=0.
- load, load_val < N_OUT: step=load_val, onehot=1<<load_val, invalid=0. err is unchanged.
- load, load_val >= N_OUT: step=load_val, onehot=0, invalid=1, err=1 (sticky until clear or reset). Same all-zero default as the one-hot decode for out-of-range codes.
- advance, valid, step < N_OUT-1: step+1, onehot shifts left by 1.
- advance, valid, step == N_OUT-1, WRAP=1: step=0, onehot=1, wrap=1 for exactly that cycle.
- advance, valid, step == N_OUT-1, WRAP=0: step and onehot hold, wrap stays 0.
- advance while invalid: no change. Recovery requires a valid load or clear.
- Arithmetic: increment is SEL_W-bit. It never overflows, because the wrap/saturate decision precedes it, including when N_OUT == 2**SEL_W.
- wrap is a pulse: 0 on every cycle not caused by a wrap advance, including cycles with simultaneous load/clear.
- done is derived from the registered step and valid flag. It is high for every cycle the last step is held.
- Invariant: onehot has exactly one bit set when not invalid and zero bits when invalid. The bench checks this every cycle.
- No X propagation: all registers have reset values. Unused step codes with N_OUT < 2**SEL_W are only reachable via load and are flagged invalid.

Test Plan:
- Reset then idle 3 cycles (defaults) -> step=0, onehot=10'b0000000001, done=0, wrap=0, err=0. Assert Resetn low mid-cycle at step 6 -> outputs return to step 0 immediately, without waiting for an edge.
- advance held 11 cycles from step 0 (WRAP=1) -> onehot walks bit 0..9; done=1 only at step 9; 10th advance gives step=0, onehot=1, wrap=1 for one cycle; 11th gives step=1, wrap=0.
- WRAP=0 build, advance held 12 cycles -> step saturates at 9, onehot=10'b1000000000, done stays 1, wrap never asserts.
- load load_val=12 -> step=12, onehot=0, err=1, done=0. Then advance x3 -> no change. Then load 3 -> onehot=10'b0000001000, err stays 1. Then clear -> step=0, err=0.
- Simultaneous commands at step 9: clear+load(5)+advance -> step=0, wrap=0. load(5)+advance -> step=5, wrap=0. advance alone -> wrap pulse.
- Parameter sweep SEL_W=3, N_OUT=8 -> advance from step 7 wraps to 0 with no overflow and no err. Random command stream of 2000 cycles is checked against a reference model plus the one-hot invariant.

Source files
------------

// File: rtl/onehot_step_sequencer.sv
// Registered step sequencer: a binary step register and a matching registered
// one-hot step bus, with load/advance/clear, wrap or saturate, and a sticky range error.
module onehot_step_sequencer #(
  parameter int SEL_W = 4,
  parameter int N_OUT = 10,
  parameter int WRAP  = 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             clear,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             advance,
  output logic [SEL_W-1:0] step,
  output logic [N_OUT-1:0] onehot,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);
  localparam logic [SEL_W:0]   NOUT = (SEL_W + 1)'(N_OUT);
  localparam logic [N_OUT-1:0] OH0  = N_OUT'(1);

  logic [SEL_W-1:0] step_q, step_d;
  logic [N_OUT-1:0] onehot_q, onehot_d;
  logic             inval_q, inval_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    step_d   = step_q;
    onehot_d = onehot_q;
    inval_d  = inval_q;
    err_d    = err_q;
    wrap_d   = 1'b0;
    if (clear) begin
      step_d   = '0;
      onehot_d = OH0;
      inval_d  = 1'b0;
      err_d    = 1'b0;
    end else if (load) begin
      step_d = load_val;
      if ({1'b0, load_val} < NOUT) begin
        onehot_d = OH0 << load_val;
        inval_d  = 1'b0;
      end else begin
        onehot_d = '0;
        inval_d  = 1'b1;
        err_d    = 1'b1;
      end
    end else if (advance && !inval_q) begin
      // Last-step decision comes before the increment so step never overflows.
      if (step_q == LAST) begin
        if (WRAP != 0) begin
          step_d   = '0;
          onehot_d = OH0;
          wrap_d   = 1'b1;
        end
      end else begin
        step_d   = step_q + SEL_W'(1);
        onehot_d = onehot_q << 1;
      end
    end
    done_d = !inval_d && (step_d == LAST);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_q   <= '0;
      onehot_q <= OH0;
      inval_q  <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      step_q   <= step_d;
      onehot_q <= onehot_d;
      inval_q  <= inval_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign step   = step_q;
  assign onehot = onehot_q;
  assign wrap   = wrap_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
